// File: rtl/nibble_add_sequencer.sv
// rtl/nibble_add_sequencer.sv - wide add/subtract by stepping a shared 4-bit adder one nibble per clock
// Operands are latched on START, B is pre-inverted for subtract, and the carry is chained through a register.
module nibble_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   RESETn,
  input  logic                   START,
  input  logic                   SUB,
  input  logic                   CIN,
  input  logic [4*NIBBLES-1:0]   OP_A,
  input  logic [4*NIBBLES-1:0]   OP_B,
  output logic [3:0]             ADD_A,
  output logic [3:0]             ADD_B,
  output logic                   ADD_CIN,
  input  logic [3:0]             ADD_SUM,
  input  logic                   ADD_COUT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [4*NIBBLES-1:0]   RESULT,
  output logic                   COUT,
  output logic                   OVF
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES) + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic          last;

  // Nibble select decoded from registered index only, so the adder path stays loop-free.
  always_comb begin
    a_nib = 4'd0;
    b_nib = 4'd0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == IW'(n)) begin
        a_nib = a_reg[4*n +: 4];
        b_nib = b_reg[4*n +: 4];
      end
    end
  end

  assign last    = (idx == IW'(NIBBLES - 1));
  assign ADD_A   = (state == S_RUN) ? a_nib : 4'd0;
  assign ADD_B   = (state == S_RUN) ? b_nib : 4'd0;
  assign ADD_CIN = (state == S_RUN) & carry;
  assign BUSY    = (state == S_RUN);
  assign DONE    = (state == S_FINISH);

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      state  <= S_IDLE;
      idx    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      carry  <= 1'b0;
      RESULT <= '0;
      COUT   <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            a_reg <= OP_A;
            b_reg <= SUB ? ~OP_B : OP_B;
            carry <= SUB | CIN;
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IW'(n)) RESULT[4*n +: 4] <= ADD_SUM;
          end
          carry <= ADD_COUT;
          if (last) begin
            // Top nibble's sum bit 3 is the result sign; B here is already the effective operand.
            COUT  <= ADD_COUT;
            OVF   <= (a_reg[W-1] == b_reg[W-1]) && (ADD_SUM[3] != a_reg[W-1]);
            state <= S_FINISH;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb/tb_nibble_add_sequencer.sv - directed self-checking bench for nibble_add_sequencer
// Models the external shared 4-bit adder and checks results, latency, pulses and reset.
module tb_nibble_add_sequencer;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sub;
  logic          cin;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [3:0]    add_a;
  logic [3:0]    add_b;
  logic          add_cin;
  logic [3:0]    add_sum;
  logic          add_cout;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          cout;
  logic          ovf;

  int checks;
  int errors;

  nibble_add_sequencer #(.NIBBLES(NIBBLES)) dut (
    .CLOCK_50 (clk),
    .RESETn   (rst_n),
    .START    (start),
    .SUB      (sub),
    .CIN      (cin),
    .OP_A     (op_a),
    .OP_B     (op_b),
    .ADD_A    (add_a),
    .ADD_B    (add_b),
    .ADD_CIN  (add_cin),
    .ADD_SUM  (add_sum),
    .ADD_COUT (add_cout),
    .BUSY     (busy),
    .DONE     (done),
    .RESULT   (result),
    .COUT     (cout),
    .OVF      (ovf)
  );

  logic [4:0] adder_full;
  assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
  assign add_sum    = adder_full[3:0];
  assign add_cout   = adder_full[4];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c, input logic [W-1:0] exp_res,
                        input logic exp_cout, input logic exp_ovf);
    int n;
    int busy_low;
    n = 0;
    busy_low = 0;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      op_a = '1; op_b = '1; sub = ~s; cin = ~c;
      n++;
      if (!done && !busy) busy_low++;
    end while (!done && n < 20);
    chk({tag, "_latency"}, n, 5);
    chk({tag, "_busy_gap"}, busy_low, 0);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_cout"}, cout, exp_cout);
    chk({tag, "_ovf"}, ovf, exp_ovf);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_hold_result"}, result, exp_res);
  endtask

  initial begin
    int dones;
    logic [W-1:0] res_at_done;
    checks = 0;
    errors = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    #5;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_add_bus", {add_a, add_b, add_cin}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_op("add",      16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    chk("idle_add_bus", {add_a, add_b, add_cin}, 0);
    run_op("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("cin",      16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_op("sub_brw",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_nob",  16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
    run_op("ovf_add",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_sub",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Second START two cycles into RUN must be ignored.
    dones = 0;
    res_at_done = '0;
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h0FFF; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) begin
        dones++;
        res_at_done = result;
      end
    end
    chk("rej_done_count", dones, 1);
    chk("rej_result", res_at_done, 16'h2233);
    chk("rej_cout", cout, 0);

    // START held high: new operation every NIBBLES+2 cycles.
    dones = 0;
    @(negedge clk);
    op_a = 16'h0001; op_b = 16'h0001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    @(negedge clk); start = 1'b0;
    chk("held_done_count", dones, 2);
    chk("held_result", result, 16'h0002);
    for (int i = 0; i < 8; i++) @(posedge clk);

    // Reset asserted during RUN clears everything immediately.
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h0FFF; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_add_bus", {add_a, add_b, add_cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_add_sequencer.md
# nibble_add_sequencer

Multi-cycle controller that performs a 4·NIBBLES-bit add or subtract by time-sharing the team's single 4-bit ripple adder (A, B, carry-in → 4-bit sum, carry-out). It latches wide operands on a start request, steps the adder one nibble per clock from LSB to MSB, and chains the carry through a register. It assembles the wide result and reports completion with a one-cycle done pulse. It sits between switch/register operand sources and the shared adder instance; the adder itself is external and purely combinational.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4·NIBBLES (legal range 1..8)

Ports:
- CLOCK_50  in  1  system clock, rising-edge
- RESETn  in  1  asynchronous, active-low reset
- START  in  1  request; sampled only in IDLE
- SUB  in  1  0 = A+B+CIN, 1 = A−B (B inverted, carry-in forced 1)
- CIN  in  1  carry-in for add mode; ignored when SUB=1
- OP_A  in  W  operand A
- OP_B  in  W  operand B
- ADD_A  out  4  nibble of A driven to shared adder
- ADD_B  out  4  nibble of B (inverted if SUB) driven to shared adder
- ADD_CIN  out  1  carry into shared adder
- ADD_SUM  in  4  sum from shared adder
- ADD_COUT  in  1  carry-out from shared adder
- BUSY  out  1  high while nibbles are being processed
- DONE  out  1  one-cycle completion pulse
- RESULT  out  W  assembled sum/difference
- COUT  out  1  final carry-out (in SUB mode, 1 = no borrow)
- OVF  out  1  two's-complement signed overflow

## Operation
- States: IDLE, RUN, FINISH.
- IDLE: ADD_A/ADD_B/ADD_CIN driven 0. If START=1 at a clock edge: latch OP_A, OP_B (inverted if SUB), SUB; carry register ← (SUB ? 1 : CIN); nibble index ← 0; go to RUN.
- RUN: ADD_A = A_reg[4i+3:4i], ADD_B = B_reg[4i+3:4i], ADD_CIN = carry register. At each edge: RESULT[4i+3:4i] ← ADD_SUM, carry register ← ADD_COUT, i ← i+1. After the edge capturing i = NIBBLES−1, go to FINISH.
- FINISH: DONE=1 for exactly one cycle; COUT = carry register; OVF = (A_reg[W−1] == B_reg[W−1]) && (RESULT[W−1] != A_reg[W−1]), using the effective (possibly inverted) B. Then return to IDLE.
- RESULT, COUT, OVF hold their values from FINISH until the next accepted START. RESULT nibbles update in place during RUN; their values are only valid once DONE is seen.
- START is ignored in RUN and FINISH; there is no queuing. Operand inputs are don't-care outside the accepting edge.
- Index counter: ceil(log2(NIBBLES))+1 bits; no wrap past NIBBLES−1.

## Timing
- Reset (async, RESETn=0): state IDLE; BUSY=0, DONE=0, RESULT=0, COUT=0, OVF=0, ADD_A=0, ADD_B=0, ADD_CIN=0, index=0, carry register=0. Takes effect immediately, including mid-RUN; the partial result is discarded.
- START accepted at edge k → BUSY=1 for cycles k+1..k+NIBBLES → DONE=1 in cycle k+NIBBLES+1 (BUSY=0 there) → IDLE at k+NIBBLES+2.
- Latency START-edge to DONE = NIBBLES+1 cycles. Minimum start-to-start spacing is NIBBLES+2 cycles.
- Shared adder path: ADD_* to ADD_SUM/ADD_COUT must settle within one CLOCK_50 period (combinational loop-free; ADD_* are registered or decoded from registered state only).
- START held high continuously → a new operation begins every NIBBLES+2 cycles.

## Test plan
- Add, NIBBLES=4: A=0x1234, B=0x0FFF, SUB=0, CIN=0 → DONE at 5 cycles after START edge; RESULT=0x2233, COUT=0, OVF=0.
- Carry wrap: A=0xFFFF, B=0x0001, CIN=0 → RESULT=0x0000, COUT=1, OVF=0; CIN=1 with A=0x0000, B=0x0000 → RESULT=0x0001.
- Subtract with borrow: A=0x0005, B=0x0007, SUB=1 → RESULT=0xFFFE, COUT=0, OVF=0; A=0x0007, B=0x0005 → RESULT=0x0002, COUT=1.
- Signed overflow: A=0x7FFF, B=0x0001 add → RESULT=0x8000, OVF=1; A=0x8000, B=0x0001 SUB → RESULT=0x7FFF, OVF=1.
- Busy rejection: START pulsed again 2 cycles after an accepted START with different operands → ignored; first result unchanged, exactly one DONE pulse.
- Reset mid-op: RESETn low during cycle 2 of RUN → BUSY, DONE, RESULT, ADD_* all 0 immediately; after release, a fresh 0x1234+0x0FFF gives 0x2233.
